entrada_pin: RTL and testbench
==============================

Name: entrada_pin

Overview:
- Keypad front end directly upstream of the parking-gate controller.
- Collects two BCD digits from a 4-bit keypad, forms the 8-bit `Pin` as {first digit, second digit}, and drives the controller's `Pin`/`enterPin` inputs.
- Issues a one-cycle `enterPin` pulse on the Enter key.
- Gated by `Vehiculo` (the vehicle must be present) and `Bloqueo` (the controller is locked).

Parameters:
- TIMEOUT_CICLOS, 200: idle cycles after the last accepted key before a partial entry is discarded (used only with PIN_TIMEOUT_EN).
- CNT_W, $clog2(TIMEOUT_CICLOS): timeout counter width.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset (Reset==0 at a rising edge resets).
- Tecla  in  4  keypad code.
  - 0-9 are digits; 4'hA is BORRAR (clear); 4'hB is ENTER.
  - 4'hC-4'hF are invalid.
- Pulsada  in  1  key-down level; synchronous to Clk; one press = one rising edge.
- Vehiculo  in  1  vehicle present at the gate.
- Bloqueo  in  1  lock indication from the controller.
- Pin  out  8  last submitted PIN, BCD {d1,d0}.
- enterPin  out  1  one-cycle submit strobe.
- Digitos  out  2  digits currently buffered (0, 1 or 2).
- Rechazo  out  1  one-cycle pulse when a key press is ignored as illegal.

Behaviour:
- Reset values: Pin=0, enterPin=0, Digitos=0, Rechazo=0, state=IDLE, buffer=0, counter=0.
- Press event: `Pulsada & ~pulsada_q`, where `pulsada_q` is `Pulsada` registered one cycle (reset 0). A held key yields exactly one event.
- States:
  - IDLE: no vehicle.
  - D0: empty buffer.
  - D1: one digit buffered.
  - FULL: two digits buffered.
  - SEND: one cycle.
- Priority per edge: Reset > ~Vehiculo > Bloqueo > press event > timeout.
- ~Vehiculo: go to IDLE, clear buffer, Digitos=0. Presses are ignored with no Rechazo.
- IDLE→D0 when Vehiculo=1.
- Bloqueo=1 with Vehiculo=1: go to D0, clear buffer, ignore presses with no Rechazo, and drive no enterPin.
- D0:
  - digit → store d1, go to D1.
  - BORRAR → stay in D0.
  - ENTER → Rechazo.
- D1:
  - digit → store d0, go to FULL.
  - BORRAR → D0.
  - ENTER → Rechazo.
- FULL:
  - digit → Rechazo; buffer unchanged.
  - BORRAR → D0.
  - ENTER → SEND.
- Any state other than IDLE: codes C-F → Rechazo, no state change.
- Entering SEND (registered at the same edge as the ENTER event):
  - Pin ← {d1,d0}, enterPin=1 for exactly that one cycle, buffer cleared.
  - Next edge → D0 (or IDLE/D0 per priority), enterPin=0.
  - A press event during the SEND cycle is ignored with no Rechazo.
- Latency: ENTER is sampled at edge N, so enterPin is high from N to N+1.
- Pin holds its value until the next SEND. Reset is the only other writer.
- Digitos mirrors the buffer: D0=0, D1=1, FULL=2.
- Rechazo is registered and asserts in the cycle after the offending event.
- Rechazo is never asserted together with enterPin.

Optional Feature:
- PIN_TIMEOUT_EN defined:
  - Counter clears on every accepted press and whenever the state is IDLE/D0/SEND.
  - Counter increments in D1 or FULL.
  - On reaching TIMEOUT_CICLOS-1 the block goes to D0 and clears the buffer, with no Rechazo.
  - A press event at the same edge wins and clears the counter.
- PIN_TIMEOUT_EN undefined: no counter is instantiated; a partial entry is held indefinitely.

Decomposition:
- Package entrada_pin_pkg:
  - state encoding IDLE/D0/D1/FULL/SEND;
  - TECLA_BORRAR=4'hA, TECLA_ENTER=4'hB;
  - DIGITO_MAX=4'd9.
- Sub-module detector_flanco: registers `Pulsada` and outputs the one-cycle press event; reset on the same synchronous active-low Reset.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1 with Vehiculo=0; press 1 → all outputs 0, state IDLE, no Rechazo.
- Vehiculo=1; press 1, 0, ENTER → Pin=8'h10, enterPin high exactly 1 cycle after the ENTER edge, Digitos goes 1,2,0.
- Keys 9, 9, ENTER → Pin=8'h99. Then 1, ENTER → Rechazo 1 cycle, enterPin stays 0, Pin stays 8'h99. Then BORRAR → Digitos=0.
- Keys 1, 0, 7 → Rechazo on the 7, Digitos=2. Then 4'hC → Rechazo. Holding Pulsada high 5 cycles on ENTER → exactly one enterPin.
- Keys 1, 0, then Bloqueo=1 and press ENTER → no enterPin, Digitos=0. With Vehiculo dropped mid-entry → state IDLE, Digitos=0.
- With PIN_TIMEOUT_EN and TIMEOUT_CICLOS=8: press 3, then wait 8 cycles → Digitos=0. A press at cycle 7 instead restarts the count.

Source files
------------

// File: rtl/entrada_pin_pkg.sv
// Shared types and key codes for the entrada_pin keypad front end.
package entrada_pin_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StD0,
    StD1,
    StFull,
    StSend
  } estado_t;

  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER  = 4'hB;
  localparam logic [3:0] DIGITO_MAX   = 4'd9;

  function automatic logic es_digito(input logic [3:0] tecla);
    return tecla <= DIGITO_MAX;
  endfunction

endpackage

// File: rtl/entrada_pin_detector_flanco.sv
// Rising-edge detector on the key-down level: one event per press.
module detector_flanco (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulsada_i,
  output logic evento_o
);

  logic pulsada_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pulsada_q <= 1'b0;
    end else begin
      pulsada_q <= pulsada_i;
    end
  end

  assign evento_o = pulsada_i & ~pulsada_q;

endmodule

// File: rtl/entrada_pin.sv
// Two-digit BCD keypad collector feeding the gate controller's Pin/enterPin.
// Optional partial-entry timeout is enabled by defining PIN_TIMEOUT_EN.
module entrada_pin
  import entrada_pin_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 200,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Tecla,
  input  logic       Pulsada,
  input  logic       Vehiculo,
  input  logic       Bloqueo,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       Rechazo
);

  estado_t    estado_q, estado_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic [7:0] pin_q, pin_d;
  logic       rechazo_q, rechazo_d;
  logic       evento;
  logic       timeout;

  detector_flanco u_detector_flanco (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .pulsada_i (Pulsada),
    .evento_o  (evento)
  );

`ifdef PIN_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parcial;

  assign parcial = (estado_q == StD1) || (estado_q == StFull);
  assign timeout = parcial && (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));

  // Only an untouched partial entry ages; any press or exit restarts from zero.
  always_comb begin
    cnt_d = '0;
    if (Vehiculo && !Bloqueo && parcial && !evento && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CICLOS ^ CNT_W;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    estado_d  = estado_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    pin_d     = pin_q;
    rechazo_d = 1'b0;
    if (!Vehiculo) begin
      estado_d = StIdle;
      d1_d     = '0;
      d0_d     = '0;
    end else if (Bloqueo) begin
      estado_d = StD0;
      d1_d     = '0;
      d0_d     = '0;
    end else begin
      unique case (estado_q)
        StIdle, StSend: estado_d = StD0;
        default: begin
          if (evento) begin
            if (es_digito(Tecla)) begin
              if (estado_q == StD0) begin
                d1_d     = Tecla;
                estado_d = StD1;
              end else if (estado_q == StD1) begin
                d0_d     = Tecla;
                estado_d = StFull;
              end else begin
                rechazo_d = 1'b1;
              end
            end else if (Tecla == TECLA_BORRAR) begin
              estado_d = StD0;
              d1_d     = '0;
              d0_d     = '0;
            end else if (Tecla == TECLA_ENTER && estado_q == StFull) begin
              pin_d    = {d1_q, d0_q};
              estado_d = StSend;
              d1_d     = '0;
              d0_d     = '0;
            end else begin
              rechazo_d = 1'b1;
            end
          end else if (timeout) begin
            estado_d = StD0;
            d1_d     = '0;
            d0_d     = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      estado_q  <= StIdle;
      d1_q      <= '0;
      d0_q      <= '0;
      pin_q     <= '0;
      rechazo_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      pin_q     <= pin_d;
      rechazo_q <= rechazo_d;
    end
  end

  always_comb begin
    Digitos = 2'd0;
    unique case (estado_q)
      StD1:    Digitos = 2'd1;
      StFull:  Digitos = 2'd2;
      default: Digitos = 2'd0;
    endcase
  end

  assign Pin      = pin_q;
  assign enterPin = (estado_q == StSend);
  assign Rechazo  = rechazo_q;

endmodule

// File: tb/tb_entrada_pin.sv
// Bench for entrada_pin: directed vector table, timeout/hold sequences, random vs. reference model.
module tb_entrada_pin;

`ifdef PIN_TIMEOUT_EN
  localparam int unsigned TO         = 8;
  localparam bit          TIMEOUT_ON = 1'b1;
`else
  localparam int unsigned TO         = 200;
  localparam bit          TIMEOUT_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Tecla = 4'd0;
  logic       Pulsada = 1'b0;
  logic       Vehiculo = 1'b0;
  logic       Bloqueo = 1'b0;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digitos;
  logic       Rechazo;

  entrada_pin #(
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Tecla    (Tecla),
    .Pulsada  (Pulsada),
    .Vehiculo (Vehiculo),
    .Bloqueo  (Bloqueo),
    .Pin      (Pin),
    .enterPin (enterPin),
    .Digitos  (Digitos),
    .Rechazo  (Rechazo)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  // Reference model: buffered digits as a queue, plus idle/sending flags.
  bit         m_idle = 1'b1;
  bit         m_send = 1'b0;
  int         m_buf[$];
  logic [7:0] m_pin = 8'h00;
  bit         m_rech = 1'b0;
  bit         m_prev = 1'b0;
  int         m_edge = 0;
  int         m_last = 0;

  typedef struct {
    bit       rst;
    bit       veh;
    bit       blq;
    bit       pul;
    bit [3:0] tec;
    int       pin;
    int       en;
    int       dig;
    int       rej;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit r, input bit v, input bit b, input bit p, input bit [3:0] t,
                     input int pin, input int en, input int dig, input int rej);
    vec_t x;
    x = '{rst: r, veh: v, blq: b, pul: p, tec: t, pin: pin, en: en, dig: dig, rej: rej};
    tbl.push_back(x);
  endtask

  task automatic model_edge();
    bit press;
    m_edge++;
    if (!Reset) begin
      m_idle = 1'b1;
      m_send = 1'b0;
      m_buf.delete();
      m_pin  = 8'h00;
      m_rech = 1'b0;
      m_prev = 1'b0;
      return;
    end
    press  = Pulsada && !m_prev;
    m_prev = Pulsada;
    m_rech = 1'b0;
    if (!Vehiculo) begin
      m_idle = 1'b1;
      m_send = 1'b0;
      m_buf.delete();
    end else if (Bloqueo) begin
      m_idle = 1'b0;
      m_send = 1'b0;
      m_buf.delete();
    end else if (m_idle || m_send) begin
      m_idle = 1'b0;
      m_send = 1'b0;
    end else if (press) begin
      m_last = m_edge;
      if (Tecla <= 4'd9) begin
        if (m_buf.size() < 2) m_buf.push_back(int'(Tecla));
        else m_rech = 1'b1;
      end else if (Tecla == 4'hA) begin
        m_buf.delete();
      end else if (Tecla == 4'hB && m_buf.size() == 2) begin
        m_pin  = 8'(m_buf[0] * 16 + m_buf[1]);
        m_send = 1'b1;
        m_buf.delete();
      end else begin
        m_rech = 1'b1;
      end
    end else if (TIMEOUT_ON && m_buf.size() > 0 && (m_edge - m_last) >= int'(TO)) begin
      m_buf.delete();
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    check("model_pin", int'(Pin), int'(m_pin));
    check("model_enterPin", int'(enterPin), int'(m_send));
    check("model_digitos", int'(Digitos), m_buf.size());
    check("model_rechazo", int'(Rechazo), int'(m_rech));
  endtask

  task automatic press_key(input logic [3:0] t);
    Tecla   = t;
    Pulsada = 1'b1;
    step();
    Pulsada = 1'b0;
    step();
  endtask

  initial begin
    // rst veh blq pul tec   pin en dig rej
    row(0, 0, 0, 0, 4'h0, 'h00, 0, 0, 0);
    row(0, 0, 0, 0, 4'h0, 'h00, 0, 0, 0);
    row(1, 0, 0, 1, 4'h1, 'h00, 0, 0, 0);
    row(1, 0, 0, 0, 4'h1, 'h00, 0, 0, 0);
    row(1, 1, 0, 0, 4'h0, 'h00, 0, 0, 0);
    row(1, 1, 0, 1, 4'h1, 'h00, 0, 1, 0);
    row(1, 1, 0, 0, 4'h1, 'h00, 0, 1, 0);
    row(1, 1, 0, 1, 4'h0, 'h00, 0, 2, 0);
    row(1, 1, 0, 0, 4'h0, 'h00, 0, 2, 0);
    row(1, 1, 0, 1, 4'hB, 'h10, 1, 0, 0);
    row(1, 1, 0, 0, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 0, 1, 4'h9, 'h10, 0, 1, 0);
    row(1, 1, 0, 0, 4'h9, 'h10, 0, 1, 0);
    row(1, 1, 0, 1, 4'h9, 'h10, 0, 2, 0);
    row(1, 1, 0, 0, 4'h9, 'h10, 0, 2, 0);
    row(1, 1, 0, 1, 4'hB, 'h99, 1, 0, 0);
    row(1, 1, 0, 0, 4'hB, 'h99, 0, 0, 0);
    row(1, 1, 0, 1, 4'h1, 'h99, 0, 1, 0);
    row(1, 1, 0, 0, 4'h1, 'h99, 0, 1, 0);
    row(1, 1, 0, 1, 4'hB, 'h99, 0, 1, 1);
    row(1, 1, 0, 0, 4'hB, 'h99, 0, 1, 0);
    row(1, 1, 0, 1, 4'hA, 'h99, 0, 0, 0);
    row(1, 1, 0, 0, 4'hA, 'h99, 0, 0, 0);
    row(1, 1, 0, 1, 4'h1, 'h99, 0, 1, 0);
    row(1, 1, 0, 0, 4'h1, 'h99, 0, 1, 0);
    row(1, 1, 0, 1, 4'h0, 'h99, 0, 2, 0);
    row(1, 1, 0, 0, 4'h0, 'h99, 0, 2, 0);
    row(1, 1, 0, 1, 4'h7, 'h99, 0, 2, 1);
    row(1, 1, 0, 0, 4'h7, 'h99, 0, 2, 0);
    row(1, 1, 0, 1, 4'hC, 'h99, 0, 2, 1);
    row(1, 1, 0, 0, 4'hC, 'h99, 0, 2, 0);
    row(1, 1, 0, 1, 4'hB, 'h10, 1, 0, 0);
    for (int i = 0; i < 4; i++) row(1, 1, 0, 1, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 0, 1, 4'h1, 'h10, 0, 1, 0);
    row(1, 1, 0, 0, 4'h1, 'h10, 0, 1, 0);
    row(1, 1, 0, 1, 4'h0, 'h10, 0, 2, 0);
    row(1, 1, 0, 0, 4'h0, 'h10, 0, 2, 0);
    row(1, 1, 1, 1, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 1, 0, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 4'hB, 'h10, 0, 0, 0);
    row(1, 1, 0, 1, 4'h3, 'h10, 0, 1, 0);
    row(1, 1, 0, 0, 4'h3, 'h10, 0, 1, 0);
    row(1, 0, 0, 0, 4'h3, 'h10, 0, 0, 0);
    row(1, 0, 0, 1, 4'h5, 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 4'h5, 'h10, 0, 0, 0);
    row(1, 1, 0, 1, 4'h5, 'h10, 0, 1, 0);
    row(1, 1, 0, 0, 4'h5, 'h10, 0, 1, 0);
    row(1, 1, 0, 1, 4'hA, 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 4'hA, 'h10, 0, 0, 0);
    row(1, 1, 0, 1, 4'hB, 'h10, 0, 0, 1);
    row(1, 1, 0, 0, 4'hB, 'h10, 0, 0, 0);

    #2;
    foreach (tbl[i]) begin
      Reset    = tbl[i].rst;
      Vehiculo = tbl[i].veh;
      Bloqueo  = tbl[i].blq;
      Pulsada  = tbl[i].pul;
      Tecla    = tbl[i].tec;
      step();
      check($sformatf("vec%0d_pin", i), int'(Pin), tbl[i].pin);
      check($sformatf("vec%0d_enterPin", i), int'(enterPin), tbl[i].en);
      check($sformatf("vec%0d_digitos", i), int'(Digitos), tbl[i].dig);
      check($sformatf("vec%0d_rechazo", i), int'(Rechazo), tbl[i].rej);
    end

    // Partial-entry lifetime.
    press_key(4'hA);
`ifdef PIN_TIMEOUT_EN
    press_key(4'h3);
    for (int i = 0; i < 6; i++) step();
    check("timeout_before", int'(Digitos), 1);
    step();
    check("timeout_fired", int'(Digitos), 0);
    check("timeout_no_rechazo", int'(Rechazo), 0);
    press_key(4'h3);
    for (int i = 0; i < 5; i++) step();
    Tecla   = 4'h4;
    Pulsada = 1'b1;
    step();
    check("restart_press", int'(Digitos), 2);
    Pulsada = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("restart_held", int'(Digitos), 2);
    step();
    check("restart_fired", int'(Digitos), 0);
`else
    press_key(4'h3);
    for (int i = 0; i < 300; i++) step();
    check("partial_held", int'(Digitos), 1);
    press_key(4'hA);
    check("partial_cleared", int'(Digitos), 0);
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      Reset    = ($urandom_range(0, 299) != 0);
      Vehiculo = ($urandom_range(0, 39) != 0);
      Bloqueo  = ($urandom_range(0, 29) == 0);
      Pulsada  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 6) Tecla = 4'($urandom_range(0, 9));
      else Tecla = 4'($urandom_range(10, 15));
      step();
      check_model();
      if (Rechazo && enterPin) check("rechazo_with_enter", 1, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
